alu_exec_serial: RTL and testbench

Execution-stage ALU that consumes the 4-bit `ALUOp` produced by the ALU control decoder. It computes the result and branch flags for one operation at a time. Logic, arithmetic and compare ops complete in one cycle. Shifts run on a serial 1-bit/cycle shifter, which keeps LUTs down on the Primer25K. The block uses a valid/ready handshake on both sides, so the EX stage stalls on `busy` while a shift is in progress.

---
 rtl/alu_exec_serial_pkg.sv | 26 ++
 rtl/alu_exec_serial_serial_shifter.sv | 56 +++++
 rtl/alu_exec_serial.sv | 134 +++++++++++++
 tb/tb_alu_exec_serial.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_serial_pkg.sv
// Shared ALU constants: datapath width, ALUOp width and the ALUOp code points
// produced by the ALU control decoder.
package alu_exec_serial_pkg;

  localparam int ALU_XLEN = 32;
  localparam int ALUOP_W  = 4;

  localparam logic [ALUOP_W-1:0] ALU_ADD   = 4'd0;
  localparam logic [ALUOP_W-1:0] ALU_SUB   = 4'd1;
  localparam logic [ALUOP_W-1:0] ALU_SUBU  = 4'd2;
  localparam logic [ALUOP_W-1:0] ALU_XOR   = 4'd3;
  localparam logic [ALUOP_W-1:0] ALU_OR    = 4'd4;
  localparam logic [ALUOP_W-1:0] ALU_AND   = 4'd5;
  localparam logic [ALUOP_W-1:0] ALU_SLL   = 4'd6;
  localparam logic [ALUOP_W-1:0] ALU_SRL   = 4'd7;
  localparam logic [ALUOP_W-1:0] ALU_SRA   = 4'd8;
  localparam logic [ALUOP_W-1:0] ALU_SLT   = 4'd9;
  localparam logic [ALUOP_W-1:0] ALU_SLTU  = 4'd10;
  localparam logic [ALUOP_W-1:0] ALU_LUI   = 4'd11;
  localparam logic [ALUOP_W-1:0] ALU_AUIPC = 4'd12;

  function automatic logic is_shift_op(input logic [ALUOP_W-1:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_exec_serial_serial_shifter.sv
// One-bit-per-cycle barrel-shifter replacement: shifts the accumulator once per
// cycle until the counter reaches zero.
module serial_shifter #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic            dir,
  input  logic            arith,
  input  logic [SHW-1:0]  amt,
  input  logic [XLEN-1:0] din,
  input  logic            kill,
  output logic [XLEN-1:0] dout,
  output logic            done
);

  logic [XLEN-1:0] acc_q;
  logic [XLEN-1:0] acc_step;
  logic [SHW-1:0]  cnt_q;
  logic            dir_q;
  logic            arith_q;

  // dir = 1 shifts right; the vacated MSB takes the sign only for arithmetic shifts
  always_comb begin
    acc_step = acc_q;
    if (dir_q) acc_step = {arith_q & acc_q[XLEN-1], acc_q[XLEN-1:1]};
    else       acc_step = {acc_q[XLEN-2:0], 1'b0};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      arith_q <= 1'b0;
    end else if (kill) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      acc_q   <= din;
      cnt_q   <= amt;
      dir_q   <= dir;
      arith_q <= arith;
    end else if (cnt_q != '0) begin
      acc_q <= acc_step;
      cnt_q <= cnt_q - SHW'(1);
    end
  end

  // dout is the value after the step being taken this cycle, so the final step lands in result directly
  assign dout = acc_step;
  assign done = (cnt_q == SHW'(1));

endmodule

// File: rtl/alu_exec_serial.sv
// Execution-stage ALU: single-cycle logic/arith/compare ops and serial shifts,
// with valid/ready handshakes on input and output.
module alu_exec_serial
  import alu_exec_serial_pkg::*;
#(
  parameter int XLEN = ALU_XLEN
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ALUOP_W-1:0] ALUOp,
  input  logic [XLEN-1:0]    inA,
  input  logic [XLEN-1:0]    inB,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    result,
  output logic               zero,
  output logic               lt,
  output logic               busy
);

  localparam int SHW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state_q;
  state_t          state_d;
  logic            accept;
  logic            start_shift;
  logic            load_direct;
  logic [SHW-1:0]  amt;
  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] diff;
  logic            slt_s;
  logic            slt_u;
  logic [XLEN-1:0] alu_res;
  logic            alu_lt;
  logic [XLEN-1:0] sh_dout;
  logic            sh_done;
  logic [XLEN-1:0] result_q;
  logic            zero_q;
  logic            lt_q;

  assign amt         = inB[SHW-1:0];
  assign accept      = in_valid && in_ready;
  assign start_shift = accept && is_shift_op(ALUOp) && (amt != '0);
  assign load_direct = accept && !start_shift;

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_d = start_shift ? SHIFT : DONE;
        SHIFT:   if (sh_done) state_d = DONE;
        DONE:    if (out_ready) state_d = accept ? (start_shift ? SHIFT : DONE) : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = !flush && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  // Zero-amount shifts take this path too and simply pass A through
  always_comb begin
    sum     = inA + inB;
    diff    = inA - inB;
    slt_s   = $signed(inA) < $signed(inB);
    slt_u   = inA < inB;
    alu_res = sum;
    alu_lt  = 1'b0;
    case (ALUOp)
      ALU_ADD, ALU_AUIPC:       alu_res = sum;
      ALU_SUB:                  begin alu_res = diff; alu_lt = slt_s; end
      ALU_SUBU:                 begin alu_res = diff; alu_lt = slt_u; end
      ALU_XOR:                  alu_res = inA ^ inB;
      ALU_OR:                   alu_res = inA | inB;
      ALU_AND:                  alu_res = inA & inB;
      ALU_SLL, ALU_SRL, ALU_SRA: alu_res = inA;
      ALU_SLT:                  begin alu_res = {{(XLEN-1){1'b0}}, slt_s}; alu_lt = slt_s; end
      ALU_SLTU:                 begin alu_res = {{(XLEN-1){1'b0}}, slt_u}; alu_lt = slt_u; end
      ALU_LUI:                  alu_res = inB;
      default:                  alu_res = sum;
    endcase
  end

  serial_shifter #(.XLEN(XLEN), .SHW(SHW)) u_shifter (
    .clock (clock),
    .reset (reset),
    .start (start_shift),
    .dir   (ALUOp != ALU_SLL),
    .arith (ALUOp == ALU_SRA),
    .amt   (amt),
    .din   (inA),
    .kill  (flush),
    .dout  (sh_dout),
    .done  (sh_done)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      result_q <= '0;
      zero_q   <= 1'b0;
      lt_q     <= 1'b0;
    end else if (!flush) begin
      if (load_direct) begin
        result_q <= alu_res;
        zero_q   <= (alu_res == '0);
        lt_q     <= alu_lt;
      end else if ((state_q == SHIFT) && sh_done) begin
        result_q <= sh_dout;
        zero_q   <= (sh_dout == '0);
        lt_q     <= 1'b0;
      end
    end
  end

  assign result = result_q;
  assign zero   = zero_q;
  assign lt     = lt_q;

endmodule

// File: tb/tb_alu_exec_serial.sv
// Scoreboard bench for alu_exec_serial: directed cases from the operation rules
// followed by randomized ops under random output backpressure.
module tb_alu_exec_serial;
  import alu_exec_serial_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        lt;
    int          n;
    int          acc_cycle;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  ALUOp = 4'd0;
  logic [31:0] inA = '0;
  logic [31:0] inB = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        zero;
  logic        lt;
  logic        busy;

  int   tests = 0;
  int   fails = 0;
  int   cycle = 0;
  bit   seen = 0;
  bit   rand_bp = 0;
  exp_t sb[$];

  alu_exec_serial #(.XLEN(32)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ALUOp(ALUOp), .inA(inA), .inB(inB), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .lt(lt), .busy(busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cycle++;

  function automatic exp_t ref_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   sh = int'(b[4:0]);
    logic s_lt = $signed(a) < $signed(b);
    logic u_lt = a < b;
    e.n = 0;
    e.lt = 1'b0;
    e.acc_cycle = 0;
    case (op)
      ALU_SUB:  begin e.res = a - b; e.lt = s_lt; end
      ALU_SUBU: begin e.res = a - b; e.lt = u_lt; end
      ALU_XOR:  e.res = a ^ b;
      ALU_OR:   e.res = a | b;
      ALU_AND:  e.res = a & b;
      ALU_SLL:  begin e.res = a << sh; e.n = sh; end
      ALU_SRL:  begin e.res = a >> sh; e.n = sh; end
      ALU_SRA:  begin e.res = $signed(a) >>> sh; e.n = sh; end
      ALU_SLT:  begin e.res = s_lt ? 32'd1 : 32'd0; e.lt = s_lt; end
      ALU_SLTU: begin e.res = u_lt ? 32'd1 : 32'd0; e.lt = u_lt; end
      ALU_LUI:  e.res = b;
      default:  e.res = a + b;
    endcase
    e.zero = (e.res == 32'd0);
    return e;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic flag_timeout(input string name);
    tests++;
    fails++;
    $display("[TB] FAIL %s: timed out at cycle %0d", name, cycle);
  endtask

  // Scoreboard push: every handshake records what the result must be and when it is due
  always @(negedge clock) begin
    if (reset || flush) begin
      sb.delete();
    end else if (in_valid && in_ready) begin
      exp_t e;
      e = ref_model(ALUOp, inA, inB);
      e.acc_cycle = cycle;
      sb.push_back(e);
    end
  end

  always @(negedge clock) begin
    if (reset || flush) begin
      seen = 0;
    end else if (out_valid) begin
      if (sb.size() == 0) begin
        check_output("spurious_out_valid", 32'(out_valid), 32'd0);
      end else begin
        if (!seen) begin
          check_output("latency", 32'(cycle), 32'(sb[0].acc_cycle + 1 + sb[0].n));
          seen = 1;
        end
        if (out_ready) begin
          check_output("result", result, sb[0].res);
          check_output("zero", 32'(zero), 32'(sb[0].zero));
          check_output("lt", 32'(lt), 32'(sb[0].lt));
          void'(sb.pop_front());
          seen = 0;
        end
      end
    end
  end

  always @(posedge clock) begin
    if (rand_bp) begin
      #1;
      if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Entered and left at posedge+1; leaves in_valid high so callers can chain ops
  task automatic apply_stimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bit got = 0;
    ALUOp = op;
    inA = a;
    inB = b;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (in_ready) begin
        got = 1;
        break;
      end
    end
    if (!got) flag_timeout("accept");
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    int i = 0;
    do begin
      @(negedge clock);
      i++;
    end while (sb.size() != 0 && i < 200);
    if (sb.size() != 0) flag_timeout("drain");
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    @(negedge clock);
    check_output({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check_output({tag, "_result"}, result, 32'd0);
    check_output({tag, "_zero"}, 32'(zero), 32'd0);
    check_output({tag, "_lt"}, 32'(lt), 32'd0);
    check_output({tag, "_busy"}, 32'(busy), 32'd0);
    check_output({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clock);
    #1;
  endtask

  initial begin
    exp_t hold;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    check_reset_state("reset");

    apply_stimulus(ALU_ADD, 32'd5, 32'd7);
    in_valid = 1'b0;
    drain();

    apply_stimulus(ALU_SUB, 32'd3, 32'd3);
    apply_stimulus(ALU_SUBU, 32'd1, 32'hFFFF_FFFF);
    apply_stimulus(ALU_SUB, 32'h8000_0000, 32'h8000_0000);
    apply_stimulus(ALU_SLT, 32'hFFFF_FFF0, 32'hFFFF_FFF0);
    apply_stimulus(ALU_SLTU, 32'h1234_5678, 32'h1234_5678);
    apply_stimulus(ALU_SLT, 32'hFFFF_FFFF, 32'd1);
    apply_stimulus(ALU_LUI, 32'hDEAD_BEEF, 32'h1234_5000);
    in_valid = 1'b0;
    drain();

    // SRA by 4: busy across the shift and done cycle, in_ready low while shifting
    apply_stimulus(ALU_SRA, 32'h8000_0000, 32'd4);
    in_valid = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clock);
      check_output("sra_busy", 32'(busy), 32'd1);
      check_output("sra_out_valid", 32'(out_valid), (i == 5) ? 32'd1 : 32'd0);
      if (i < 5) check_output("sra_in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clock);
    check_output("sra_busy_after", 32'(busy), 32'd0);
    @(posedge clock);
    #1;
    apply_stimulus(ALU_SRL, 32'h8000_0000, 32'd4);
    apply_stimulus(ALU_SLL, 32'h8000_0000, 32'd0);
    in_valid = 1'b0;
    drain();

    // Backpressure: result held stable, then retire and accept on the same edge
    out_ready = 1'b0;
    apply_stimulus(ALU_XOR, 32'hF0F0_1234, 32'h0F0F_1234);
    hold = ref_model(ALU_XOR, 32'hF0F0_1234, 32'h0F0F_1234);
    ALUOp = ALU_OR;
    inA = 32'h0000_00F0;
    inB = 32'h0000_000F;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_output("bp_out_valid", 32'(out_valid), 32'd1);
      check_output("bp_result", result, hold.res);
      check_output("bp_zero", 32'(zero), 32'(hold.zero));
      check_output("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    apply_stimulus(ALU_OR, 32'h0000_00F0, 32'h0000_000F);
    in_valid = 1'b0;
    drain();

    // Flush two cycles into an SLL by 10
    apply_stimulus(ALU_SLL, 32'h0000_0001, 32'd10);
    in_valid = 1'b0;
    @(posedge clock);
    #1;
    flush = 1'b1;
    @(negedge clock);
    check_output("flush_in_ready", 32'(in_ready), 32'd0);
    @(posedge clock);
    #1;
    flush = 1'b0;
    @(negedge clock);
    check_output("flush_busy", 32'(busy), 32'd0);
    check_output("flush_in_ready_after", 32'(in_ready), 32'd1);
    repeat (15) @(negedge clock);
    @(posedge clock);
    #1;

    // Reset mid-SRA, then reset while holding a DONE result
    apply_stimulus(ALU_SRA, 32'h8000_0000, 32'd20);
    in_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check_reset_state("reset_shift");
    out_ready = 1'b0;
    apply_stimulus(ALU_ADD, 32'd1, 32'd2);
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    check_reset_state("reset_done");
    apply_stimulus(ALU_ADD, 32'd100, 32'd23);
    apply_stimulus(4'd15, 32'h7FFF_FFFF, 32'd1);
    apply_stimulus(ALU_AUIPC, 32'h0000_1000, 32'hFFFF_F000);
    in_valid = 1'b0;
    drain();

    rand_bp = 1;
    for (int i = 0; i < 120; i++) begin
      logic [3:0]  op = 4'($urandom_range(0, 15));
      logic [31:0] a = $urandom();
      logic [31:0] b = ($urandom_range(0, 3) == 0) ? a : $urandom();
      if (is_shift_op(op) && $urandom_range(0, 1) == 1) b = 32'($urandom_range(0, 7));
      apply_stimulus(op, a, b);
      if ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clock);
        #1;
      end
    end
    in_valid = 1'b0;
    rand_bp = 0;
    @(posedge clock);
    #2;
    out_ready = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
